// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the tpu: forwards kernel then matrix bytes, then collects results into a FIFO.
// Build option: define TPU_SEQ_PERF_EN to add the cycles[31:0] busy-cycle counter output.
`timescale 1ns/1ps
module tpu_host_seq #(
    parameter int DATA_W     = 8,
    parameter int CONV_LEN   = 9,
    parameter int MAT_LEN    = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int SLACK      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tpu_insert_kernal,
    output logic              tpu_write_mode,
    output logic              tpu_write,
    output logic [DATA_W-1:0] tpu_data_in,
    output logic              tpu_ready,
    input  logic              tpu_done,
    input  logic [DATA_W-1:0] tpu_data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [31:0]       cycles
`endif
);

    localparam int CNT_W = $clog2(MAT_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(FIFO_DEPTH - SLACK);
    localparam logic [OCC_W-1:0] FULL_LEVEL  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] KERNEL_LAST = CNT_W'(CONV_LEN - 1);
    localparam logic [CNT_W-1:0] MATRIX_LAST = CNT_W'(MAT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_KERNEL,
        S_KFLUSH1,
        S_KFLUSH2,
        S_MATRIX,
        S_MFLUSH1,
        S_MFLUSH2,
        S_RECV,
        S_DRAIN
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ, occ_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              accept, recv_done, full, push, pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_KERNEL;
            S_KERNEL:  if (accept && cnt == KERNEL_LAST) state_next = S_KFLUSH1;
            S_KFLUSH1: state_next = S_KFLUSH2;
            S_KFLUSH2: state_next = S_MATRIX;
            S_MATRIX:  if (accept && cnt == MATRIX_LAST) state_next = S_MFLUSH1;
            S_MFLUSH1: state_next = S_MFLUSH2;
            S_MFLUSH2: state_next = S_RECV;
            S_RECV:    if (recv_done && cnt == MATRIX_LAST) state_next = S_DRAIN;
            S_DRAIN:   if (occ == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        busy      = (state != S_IDLE);
        in_ready  = (state == S_KERNEL) || (state == S_MATRIX);
        accept    = in_valid && in_ready;
        recv_done = (state == S_RECV) && tpu_done;
        full      = (occ == FULL_LEVEL);
        out_valid = (occ != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        pop       = out_valid && out_ready;
        push      = recv_done && (!full || pop);
        occ_next  = occ + OCC_W'(push) - OCC_W'(pop);
    end

    // Flush cycle 1 repeats the write strobe once; flush cycle 2 drops the strobe and phase flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpu_insert_kernal <= 1'b0;
            tpu_write_mode    <= 1'b0;
            tpu_write         <= 1'b0;
            tpu_data_in       <= '0;
            tpu_ready         <= 1'b0;
        end else begin
            tpu_write <= accept || (state == S_KFLUSH1) || (state == S_MFLUSH1);
            if (accept) tpu_data_in <= in_data;
            if (state == S_IDLE && start) begin
                tpu_insert_kernal <= 1'b1;
                tpu_write_mode    <= 1'b1;
            end
            if (state == S_KFLUSH2) tpu_insert_kernal <= 1'b0;
            if (state == S_MFLUSH2) tpu_write_mode <= 1'b0;
            tpu_ready <= (state_next == S_RECV) && (occ_next < READY_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (state_next != state)        cnt <= '0;
            else if (accept || recv_done)   cnt <= cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ_next;
            if (recv_done && full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tpu_data_out;
    end

`ifdef TPU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cycles <= '0;
        else if (state == S_IDLE && start) cycles <= '0;
        else if (busy && cycles != '1)  cycles <= cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scoreboard bench for tpu_host_seq: directed jobs feed expected queues, monitors compare tpu writes and FIFO pops.
`timescale 1ns/1ps
module tb_tpu_host_seq;

    localparam int DATA_W   = 8;
    localparam int CONV_LEN = 9;
    localparam int MAT_LEN  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              tpu_done = 1'b0;
    logic [DATA_W-1:0] tpu_data_out = '0;
    logic              out_ready = 1'b0;
    logic              busy, in_ready, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready;
    logic              out_valid, overflow;
    logic [DATA_W-1:0] tpu_data_in, out_data;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0]       cycles;
`endif

    always #5 clk = ~clk;

    tpu_host_seq #(
        .DATA_W(DATA_W), .CONV_LEN(CONV_LEN), .MAT_LEN(MAT_LEN), .FIFO_DEPTH(4), .SLACK(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tpu_insert_kernal(tpu_insert_kernal), .tpu_write_mode(tpu_write_mode),
        .tpu_write(tpu_write), .tpu_data_in(tpu_data_in), .tpu_ready(tpu_ready),
        .tpu_done(tpu_done), .tpu_data_out(tpu_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow)
`ifdef TPU_SEQ_PERF_EN
        , .cycles(cycles)
`endif
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ins;
    } wr_exp_t;

    wr_exp_t           exp_wr[$];
    logic [DATA_W-1:0] exp_out[$];
    bit                wr_trace[$];
    bit                trace_en = 1'b0;
    int                busy_cnt = 0;
    int                checks = 0;
    int                failures = 0;

    int   model_mode = 0;
    int   res_idx = 0;
    int   burst_left = 0;
    int   drop_idx = -1;
    logic rdy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] res_byte(input int k);
        return DATA_W'(k * 13 + 7);
    endfunction

    function automatic logic [DATA_W-1:0] mat_byte(input int k);
        return DATA_W'(k) ^ 8'hA5;
    endfunction

    // Write monitor: every write-high cycle must carry the next expected byte and phase flags.
    always @(negedge clk) begin : mon_wr
        wr_exp_t w;
        if (trace_en) wr_trace.push_back(tpu_write);
        if (busy) busy_cnt++;
        if (tpu_write) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(tpu_data_in), 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check("wr_data", 32'(tpu_data_in), 32'(w.data));
                check("wr_insert", 32'(tpu_insert_kernal), 32'(w.ins));
                check("wr_mode", 32'(tpu_write_mode), 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon_out
        logic [DATA_W-1:0] e;
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                check("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_out.pop_front();
                check("out_data", 32'(out_data), 32'(e));
            end
        end
    end

    // Tpu model: mode 1 answers one cycle after seeing ready; mode 2 fires a burst ignoring ready.
    always @(negedge clk) rdy_seen = tpu_ready;

    always @(posedge clk) begin : tpu_model
        #1;
        tpu_done = 1'b0;
        if ((model_mode == 1 && rdy_seen && res_idx < MAT_LEN) || (model_mode == 2 && burst_left > 0)) begin
            tpu_done     = 1'b1;
            tpu_data_out = res_byte(res_idx);
            if (res_idx != drop_idx) exp_out.push_back(res_byte(res_idx));
            res_idx++;
            if (model_mode == 2) burst_left--;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the last accepted beat.
    task automatic send_stream(input bit kern, input int n, input int stall_every);
        int i = 0;
        int cyc = 0;
        logic [DATA_W-1:0] b;
        while (i < n && cyc < 5000) begin
            b        = kern ? DATA_W'(i + 1) : mat_byte(i);
            in_valid = !(stall_every > 0 && (cyc % stall_every) == stall_every - 1);
            in_data  = b;
            cyc++;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_wr.push_back('{data: b, ins: kern});
                i++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check(kern ? "kernel_beats" : "matrix_beats", 32'(i), 32'(n));
    endtask

    task automatic load_job(input int stall_every);
        send_stream(1'b1, CONV_LEN, 0);
        exp_wr.push_back('{data: DATA_W'(CONV_LEN), ins: 1'b1});
        send_stream(1'b0, MAT_LEN, stall_every);
        exp_wr.push_back('{data: mat_byte(MAT_LEN - 1), ins: 1'b0});
    endtask

    task automatic wait_ready(input string name);
        int g = 0;
        do begin @(negedge clk); g++; end while (!tpu_ready && g < 5000);
        check(name, 32'(tpu_ready), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 5000);
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ctl"}, 32'({in_ready, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready}), 32'd0);
        check({tag, "_data"}, 32'({tpu_data_in, out_data}), 32'd0);
        check({tag, "_out"}, 32'({out_valid, overflow}), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [5:0] pat;
        int ones, run, gap, k;

        #2 rst_n = 1'b0;
        #1 check_quiet("reset");
        @(negedge clk) rst_n = 1'b1;

        // Job 1: abort with reset after 40 matrix beats.
        pulse_start();
        send_stream(1'b1, CONV_LEN, 0);
        exp_wr.push_back('{data: DATA_W'(CONV_LEN), ins: 1'b1});
        send_stream(1'b0, 40, 0);
        rst_n = 1'b0;
        #1 check_quiet("abort");
        check("abort_pending_writes", 32'(exp_wr.size()), 32'd1);
        exp_wr.delete();
        @(negedge clk) rst_n = 1'b1;

        // Job 2: full replay, matrix stalls every 4th cycle, stray start mid-job, FIFO fill with out_ready=0.
        out_ready  = 1'b0;
        res_idx    = 0;
        drop_idx   = -1;
        model_mode = 1;
        wr_trace.delete();
        trace_en = 1'b1;
        pulse_start();
        send_stream(1'b1, CONV_LEN, 0);
        exp_wr.push_back('{data: DATA_W'(CONV_LEN), ins: 1'b1});
        fork
            begin
                repeat (30) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join_none
        send_stream(1'b0, MAT_LEN, 4);
        exp_wr.push_back('{data: mat_byte(MAT_LEN - 1), ins: 1'b0});
        wait_ready("recv_ready_rise");
        trace_en = 1'b0;
        for (int j = 0; j < 6; j++) begin
            pat[j] = tpu_ready;
            if (j < 5) @(negedge clk);
        end
        check("ready_pattern", 32'(pat), 32'(6'b000111));
        check("fill_valid", 32'(out_valid), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle("job2_done");
        check("job2_results_sent", 32'(res_idx), 32'(MAT_LEN));
        check("job2_results_pending", 32'(exp_out.size()), 32'd0);
        check("job2_writes_pending", 32'(exp_wr.size()), 32'd0);
        check("job2_overflow", 32'(overflow), 32'd0);

        ones = 0; run = 0; gap = 0; k = 0;
        foreach (wr_trace[j]) if (wr_trace[j]) ones++;
        while (k < wr_trace.size() && !wr_trace[k]) k++;
        while (k < wr_trace.size() && wr_trace[k]) begin run++; k++; end
        while (k < wr_trace.size() && !wr_trace[k]) begin gap++; k++; end
        check("kernel_write_run", 32'(run), 32'(CONV_LEN + 1));
        check("kernel_matrix_gap", 32'(gap), 32'd1);
        check("total_write_cycles", 32'(ones), 32'(CONV_LEN + 1 + MAT_LEN + 1));

        // Job 3: model ignores ready, five results into a 4-deep FIFO with no consumer.
        @(posedge clk); #1 out_ready = 1'b0;
        model_mode = 0;
        res_idx    = 0;
        drop_idx   = 4;
        pulse_start();
        load_job(0);
        wait_ready("ovf_ready_rise");
        burst_left = 5;
        model_mode = 2;
        repeat (7) @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_ready_low", 32'(tpu_ready), 32'd0);
        check("ovf_valid", 32'(out_valid), 32'd1);
        model_mode = 1;
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle("ovf_job_done");
        check("ovf_results_pending", 32'(exp_out.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

`ifdef TPU_SEQ_PERF_EN
        // Job 4: no stalls, consumer always ready; busy-cycle counter against measured busy cycles.
        res_idx    = 0;
        drop_idx   = -1;
        model_mode = 1;
        busy_cnt   = 0;
        pulse_start();
        load_job(0);
        wait_idle("perf_job_done");
        check("perf_cycles", cycles, 32'(busy_cnt));
        repeat (5) @(negedge clk);
        check("perf_hold", cycles, 32'(busy_cnt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
